// File: rtl/conv_buf_pkg.sv
// -----------------------------------------------------------------------------
// conv_buf_pkg
// Shared definitions for the ping-pong convolution window buffer:
//   - default frame geometry (28x28 frames, 1-bit pixels, 5-row window)
//   - address-width helper and the derived default address widths
//   - bank-state encoding used by the per-bank FSM (EMPTY/FILL/FULL/READ)
// No ports (package).
// -----------------------------------------------------------------------------
package conv_buf_pkg;

   localparam int DEF_IMG_W = 28;
   localparam int DEF_IMG_H = 28;
   localparam int DEF_PIX_W = 1;
   localparam int DEF_K     = 5;

   // Address width for an n-entry range; never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_COL_W = addr_w(DEF_IMG_W);
   localparam int DEF_ROW_W = addr_w(DEF_IMG_H);

   // Bank-state encoding for the per-bank FSM.
   typedef logic [1:0] bank_state_t;
   localparam bank_state_t BANK_EMPTY = 2'd0;
   localparam bank_state_t BANK_FILL  = 2'd1;
   localparam bank_state_t BANK_FULL  = 2'd2;
   localparam bank_state_t BANK_READ  = 2'd3;

endpackage

// File: rtl/conv_line_ram.sv
// -----------------------------------------------------------------------------
// conv_line_ram
// Simple dual-port line memory, DEPTH x WIDTH, one write port and one read
// port with a registered read. The read register only updates when re_i is
// high, so rdata_o holds its last value between reads. Contents and the read
// register are not reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module conv_line_ram
   import conv_buf_pkg::*;
#(
   parameter int DEPTH = DEF_IMG_W,
   parameter int WIDTH = DEF_PIX_W,
   localparam int AW   = addr_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window_buf.sv
// -----------------------------------------------------------------------------
// conv_window_buf
// Ping-pong frame buffer between the downsampler and the convolution engine.
// Two banks each hold a whole IMG_W x IMG_H frame; one is filled while the
// other is read as K-row window columns. A cal_start pulse announces each
// complete frame; the conv engine hands the bank back with rd_done.
//
// Optional feature macro: CONV_WIN_ZERO_PAD_EN
//   defined   : rd_row is the window centre, rows outside the frame read as 0
//               (K must be odd), rd_row valid over 0..IMG_H-1
//   undefined : rd_row is the window top row, no padding logic
//
// Handshake semantics: pix_vld is a one-cycle write strobe accepted only when
// in_ready is high and the coordinates are in range; a strobe while in_ready
// is low is dropped and sets the sticky ovf flag. rd_en in cycle N yields
// col_vld/col_data in cycle N+1; col_data holds between reads. cal_start and
// rd_done are single-cycle pulses.
//
// Ports:
//   sclk           in   clock, rising edge
//   s_rst_n        in   asynchronous active-low reset
//   pix_data       in   pixel to store
//   pix_vld        in   pixel write strobe
//   pix_col        in   pixel column
//   pix_row        in   pixel row
//   in_ready       out  write bank is EMPTY or FILL
//   rd_col         in   window column read address
//   rd_row         in   window top row (centre row with padding)
//   rd_en          in   window read request
//   col_data       out  window column, slice i = row (top+i)
//   col_vld        out  col_data valid
//   cal_start      out  one-cycle pulse, a frame is ready for reading
//   rd_done        in   one-cycle pulse, release read bank
//   rd_bank        out  bank currently being read
//   ovf            out  sticky, a pixel was dropped
//   bank_state_dbg out  {bank1 state, bank0 state} for observation
// -----------------------------------------------------------------------------
module conv_window_buf
   import conv_buf_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = DEF_PIX_W,
   parameter int K     = DEF_K,
   localparam int COL_W = addr_w(IMG_W),
   localparam int ROW_W = addr_w(IMG_H)
) (
   input  logic               sclk,
   input  logic               s_rst_n,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_vld,
   input  logic [COL_W-1:0]   pix_col,
   input  logic [ROW_W-1:0]   pix_row,
   output logic               in_ready,
   input  logic [COL_W-1:0]   rd_col,
   input  logic [ROW_W-1:0]   rd_row,
   input  logic               rd_en,
   output logic [K*PIX_W-1:0] col_data,
   output logic               col_vld,
   output logic               cal_start,
   input  logic               rd_done,
   output logic               rd_bank,
   output logic               ovf,
   output logic [3:0]         bank_state_dbg
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
`ifndef CONV_WIN_ZERO_PAD_EN
   localparam logic [ROW_W-1:0] LAST_TOP = ROW_W'(IMG_H - K);
`endif

   // ---------------------------------------------------------------------
   // Bank control
   // ---------------------------------------------------------------------
   bank_state_t st_q [2];
   bank_state_t st_d [2];
   logic        wr_bank_q, wr_bank_d;
   logic        rd_bank_q, rd_bank_d;
   logic        nxt_rd_q, nxt_rd_d;   // bank holding the oldest unread frame
   logic        cal_start_q, cal_start_d;
   logic        ovf_q, ovf_d;

   logic wr_acc;
   logic wr_last;
   logic wr_drop;

   assign in_ready = (st_q[wr_bank_q] == BANK_EMPTY) || (st_q[wr_bank_q] == BANK_FILL);
   assign wr_acc   = pix_vld && in_ready && (pix_col <= LAST_COL) && (pix_row <= LAST_ROW);
   assign wr_last  = wr_acc && (pix_col == LAST_COL) && (pix_row == LAST_ROW);
   assign wr_drop  = pix_vld && !in_ready;

   always_comb begin
      st_d        = st_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      nxt_rd_d    = nxt_rd_q;
      cal_start_d = 1'b0;
      ovf_d       = ovf_q || wr_drop;

      if (wr_acc) begin
         if (wr_last) begin
            st_d[wr_bank_q] = BANK_FULL;
            wr_bank_d       = ~wr_bank_q;
         end else if (st_q[wr_bank_q] == BANK_EMPTY) begin
            st_d[wr_bank_q] = BANK_FILL;
         end
      end

      if (rd_done && (st_q[rd_bank_q] == BANK_READ)) begin
         st_d[rd_bank_q] = BANK_EMPTY;
      end

      // Hand the oldest full frame to the reader as soon as no bank is being
      // read. Evaluated on the post-update states so a frame completing (or a
      // release) this cycle is announced on the very next cycle; FULL is only
      // held across cycles while the other bank is still being read.
      if ((st_d[0] != BANK_READ) && (st_d[1] != BANK_READ) &&
          (st_d[nxt_rd_q] == BANK_FULL)) begin
         st_d[nxt_rd_q] = BANK_READ;
         rd_bank_d      = nxt_rd_q;
         nxt_rd_d       = ~nxt_rd_q;
         cal_start_d    = 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         st_q[0]     <= BANK_EMPTY;
         st_q[1]     <= BANK_EMPTY;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         nxt_rd_q    <= 1'b0;
         cal_start_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         st_q[0]     <= st_d[0];
         st_q[1]     <= st_d[1];
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         nxt_rd_q    <= nxt_rd_d;
         cal_start_q <= cal_start_d;
         ovf_q       <= ovf_d;
      end
   end

   assign cal_start      = cal_start_q;
   assign rd_bank        = rd_bank_q;
   assign ovf            = ovf_q;
   assign bank_state_dbg = {st_q[1], st_q[0]};

   // ---------------------------------------------------------------------
   // Line memories: one per (bank, row), all read at rd_col on rd_en
   // ---------------------------------------------------------------------
   logic [PIX_W-1:0] ram_rdata [2][IMG_H];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar r = 0; r < IMG_H; r++) begin : g_row
         conv_line_ram #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
         ) u_line (
            .clk_i   (sclk),
            .we_i    (wr_acc && (wr_bank_q == 1'(b)) && (pix_row == ROW_W'(r))),
            .waddr_i (pix_col),
            .wdata_i (pix_data),
            .re_i    (rd_en),
            .raddr_i (rd_col),
            .rdata_o (ram_rdata[b][r])
         );
      end
   end

   // ---------------------------------------------------------------------
   // Window read path: selectors captured alongside the RAM read so the
   // output mux and the RAM registers stay aligned and hold together.
   // ---------------------------------------------------------------------
   logic             col_vld_q;
   logic             rd_zero_q, rd_zero_d;
   logic             rd_sel_q;
   logic [ROW_W-1:0] rd_row_q;

   always_comb begin
      rd_zero_d = (st_q[rd_bank_q] != BANK_READ) || (rd_col > LAST_COL);
`ifdef CONV_WIN_ZERO_PAD_EN
      if (rd_row > LAST_ROW) rd_zero_d = 1'b1;
`else
      if (rd_row > LAST_TOP) rd_zero_d = 1'b1;
`endif
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         col_vld_q <= 1'b0;
         rd_zero_q <= 1'b1;   // forces col_data to zero out of reset
         rd_sel_q  <= 1'b0;
         rd_row_q  <= '0;
      end else begin
         col_vld_q <= rd_en;
         if (rd_en) begin
            rd_zero_q <= rd_zero_d;
            rd_sel_q  <= rd_bank_q;
            rd_row_q  <= rd_row;
         end
      end
   end

   logic [ROW_W-1:0] row_idx;
`ifdef CONV_WIN_ZERO_PAD_EN
   logic signed [ROW_W+1:0] row_s;
`endif

   always_comb begin
      col_data = '0;
      row_idx  = '0;
`ifdef CONV_WIN_ZERO_PAD_EN
      row_s    = '0;
`endif
      if (!rd_zero_q) begin
         for (int i = 0; i < K; i++) begin
`ifdef CONV_WIN_ZERO_PAD_EN
            // Centre-aligned: rows above the top or below the bottom read 0.
            row_s = $signed({2'b00, rd_row_q}) + $signed((ROW_W+2)'(i))
                    - $signed((ROW_W+2)'(K / 2));
            if (!row_s[ROW_W+1] && (row_s <= $signed({2'b00, LAST_ROW}))) begin
               row_idx = row_s[ROW_W-1:0];
               col_data[i*PIX_W +: PIX_W] = ram_rdata[rd_sel_q][row_idx];
            end
`else
            row_idx = rd_row_q + ROW_W'(i);
            col_data[i*PIX_W +: PIX_W] = ram_rdata[rd_sel_q][row_idx];
`endif
         end
      end
   end

   assign col_vld = col_vld_q;

endmodule

// File: tb/tb_conv_window_buf.sv
// -----------------------------------------------------------------------------
// tb_conv_window_buf
// Directed bench for conv_window_buf with default geometry (28x28, PIX_W=1,
// K=5). Frames are generated from small pixel patterns; expected window
// columns come from a reference model of the frame and literal constants.
// Build with CONV_WIN_ZERO_PAD_EN defined to exercise the padded window.
// -----------------------------------------------------------------------------
module tb_conv_window_buf;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 1;
  localparam int K     = 5;
  localparam int COL_W = 5;
  localparam int ROW_W = 5;
  localparam int CW    = K * PIX_W;

  localparam int PAT_CHK  = 0;  // (col ^ row) & 1
  localparam int PAT_LT   = 1;  // col < row
  localparam int PAT_MOD3 = 2;  // (col + row) % 3 == 0
  localparam int PAT_ONES = 3;  // all ones

  // ---------------- clock / reset ----------------
  logic sclk = 1'b0;
  logic s_rst_n;
  always #5 sclk = ~sclk;

  logic [PIX_W-1:0] pix_data;
  logic             pix_vld;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic             in_ready;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic             rd_en;
  logic [CW-1:0]    col_data;
  logic             col_vld;
  logic             cal_start;
  logic             rd_done;
  logic             rd_bank;
  logic             ovf;
  logic [3:0]       bank_state_dbg;

  conv_window_buf dut (
    .sclk           (sclk),
    .s_rst_n        (s_rst_n),
    .pix_data       (pix_data),
    .pix_vld        (pix_vld),
    .pix_col        (pix_col),
    .pix_row        (pix_row),
    .in_ready       (in_ready),
    .rd_col         (rd_col),
    .rd_row         (rd_row),
    .rd_en          (rd_en),
    .col_data       (col_data),
    .col_vld        (col_vld),
    .cal_start      (cal_start),
    .rd_done        (rd_done),
    .rd_bank        (rd_bank),
    .ovf            (ovf),
    .bank_state_dbg (bank_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic pix_of(input int pat, input int c, input int r);
    case (pat)
      PAT_CHK:  return ((c ^ r) & 1) != 0;
      PAT_LT:   return c < r;
      PAT_MOD3: return ((c + r) % 3) == 0;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [CW-1:0] exp_col(input int pat, input int c, input int r);
    logic [CW-1:0] v;
    v = '0;
    if (c >= IMG_W) return '0;
`ifdef CONV_WIN_ZERO_PAD_EN
    if (r >= IMG_H) return '0;
    for (int i = 0; i < K; i++) begin
      int rr;
      rr = r - K / 2 + i;
      if (rr >= 0 && rr < IMG_H) v[i] = pix_of(pat, c, rr);
    end
`else
    if (r > IMG_H - K) return '0;
    for (int i = 0; i < K; i++) v[i] = pix_of(pat, c, r + i);
`endif
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Row-major write of the first n pixels; optional rd_done on the last one.
  task automatic write_pixels(input int pat, input int n, input bit done_on_last);
    for (int idx = 0; idx < n; idx++) begin
      pix_vld  = 1'b1;
      pix_col  = COL_W'(idx % IMG_W);
      pix_row  = ROW_W'(idx / IMG_W);
      pix_data = pix_of(pat, idx % IMG_W, idx / IMG_W);
      rd_done  = done_on_last && (idx == n - 1);
      tick();
    end
    pix_vld = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic do_read(input string tag, input int pat, input int c, input int r);
    rd_en  = 1'b1;
    rd_col = COL_W'(c);
    rd_row = ROW_W'(r);
    exp_q.push_back(exp_col(pat, c, r));
    tick();
    rd_en = 1'b0;
    check({tag, "_vld"}, 32'(col_vld), 32'd1);
    check({tag, "_data"}, 32'(col_data), 32'(exp_q.pop_front()));
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    s_rst_n  = 1'b0;
    pix_data = '0;
    pix_vld  = 1'b0;
    pix_col  = '0;
    pix_row  = '0;
    rd_col   = '0;
    rd_row   = '0;
    rd_en    = 1'b0;
    rd_done  = 1'b0;
    repeat (3) tick();

    check("rst_col_vld",   32'(col_vld),        32'd0);
    check("rst_col_data",  32'(col_data),       32'd0);
    check("rst_cal_start", 32'(cal_start),      32'd0);
    check("rst_in_ready",  32'(in_ready),       32'd1);
    check("rst_rd_bank",   32'(rd_bank),        32'd0);
    check("rst_ovf",       32'(ovf),            32'd0);
    check("rst_states",    32'(bank_state_dbg), 32'h0);
    s_rst_n = 1'b1;
    tick();

    // Read with no bank in READ returns a valid all-zero column.
    rd_en = 1'b1; rd_col = 5'd3; rd_row = 5'd0;
    tick();
    rd_en = 1'b0;
    check("idle_rd_vld",  32'(col_vld),  32'd1);
    check("idle_rd_data", 32'(col_data), 32'd0);
    tick();
    check("idle_vld_low", 32'(col_vld),  32'd0);

    // rd_done with nothing in READ is ignored.
    pulse_rd_done();
    check("stray_done_cal", 32'(cal_start),      32'd0);
    check("stray_done_st",  32'(bank_state_dbg), 32'h0);

    // Out-of-range writes are ignored without flagging; column 28 on the
    // last row must not complete the frame.
    pix_vld = 1'b1; pix_col = 5'd28; pix_row = 5'd27; pix_data = 1'b1;
    tick();
    pix_col = 5'd5; pix_row = 5'd28;
    tick();
    pix_vld = 1'b0;
    tick();
    check("oor_ovf",   32'(ovf),            32'd0);
    check("oor_cal",   32'(cal_start),      32'd0);
    check("oor_state", 32'(bank_state_dbg), 32'h0);

    // Frame 1: checkerboard into bank 0; cal_start in the cycle after the
    // last write.
    write_pixels(PAT_CHK, IMG_W * IMG_H, 1'b0);
    check("f1_cal_start", 32'(cal_start),      32'd1);
    check("f1_rd_bank",   32'(rd_bank),        32'd0);
    check("f1_in_ready",  32'(in_ready),       32'd1);
    check("f1_states",    32'(bank_state_dbg), 32'h3);
    tick();
    check("f1_cal_pulse", 32'(cal_start),      32'd0);

    do_read("f1_c3r0", PAT_CHK, 3, 0);
`ifndef CONV_WIN_ZERO_PAD_EN
    // col 3, rows 0..4: 3^0..3^4 = 3,2,1,0,7 -> bits 1,0,1,0,1
    check("f1_c3r0_lit", 32'(col_data), 32'h15);
`endif

    // Back-to-back reads every cycle.
    for (int c = 0; c < 6; c++) begin
      rd_en  = 1'b1;
      rd_col = COL_W'(c);
      rd_row = 5'd2;
      exp_q.push_back(exp_col(PAT_CHK, c, 2));
      tick();
      check("burst_vld",  32'(col_vld),  32'd1);
      check("burst_data", 32'(col_data), 32'(exp_q.pop_front()));
    end
    rd_en = 1'b0;
    tick();
    check("burst_end_vld", 32'(col_vld),  32'd0);
    check("burst_hold",    32'(col_data), 32'(exp_col(PAT_CHK, 5, 2)));

    // Window boundaries.
    do_read("f1_c27r23", PAT_CHK, 27, 23);
    do_read("f1_c0r24",  PAT_CHK, 0, 24);
    do_read("f1_c28r0",  PAT_CHK, 28, 0);
`ifndef CONV_WIN_ZERO_PAD_EN
    check("f1_c28r0_lit", 32'(col_data), 32'd0);
`endif

    // Frame 2 into bank 1 while bank 0 is read: held until release.
    write_pixels(PAT_LT, IMG_W * IMG_H, 1'b0);
    check("f2_no_cal",   32'(cal_start),      32'd0);
    check("f2_in_ready", 32'(in_ready),       32'd0);
    check("f2_states",   32'(bank_state_dbg), 32'hB);
    tick();
    check("f2_still_no_cal", 32'(cal_start), 32'd0);
    do_read("f1_again", PAT_CHK, 10, 7);

    // Frame 3 with both banks occupied: every pixel dropped.
    write_pixels(PAT_ONES, IMG_W * IMG_H, 1'b0);
    check("f3_ovf",    32'(ovf),            32'd1);
    check("f3_no_cal", 32'(cal_start),      32'd0);
    check("f3_states", 32'(bank_state_dbg), 32'hB);

    // Release bank 0: frame 2 announced on the next cycle from bank 1.
    pulse_rd_done();
    check("f2_cal_start", 32'(cal_start), 32'd1);
    check("f2_rd_bank",   32'(rd_bank),   32'd1);
    check("f2_ovf_kept",  32'(ovf),       32'd1);
    check("f2_in_ready",  32'(in_ready),  32'd1);
    do_read("f2_c0r0",   PAT_LT, 0, 0);
    do_read("f2_c10r3",  PAT_LT, 10, 3);
    do_read("f2_c5r20",  PAT_LT, 5, 20);
    do_read("f2_c27r23", PAT_LT, 27, 23);

    // Frame 4 into bank 0 with rd_done coinciding with its last pixel.
    write_pixels(PAT_MOD3, IMG_W * IMG_H, 1'b1);
    check("f4_cal_start", 32'(cal_start),      32'd1);
    check("f4_rd_bank",   32'(rd_bank),        32'd0);
    check("f4_states",    32'(bank_state_dbg), 32'h3);
    do_read("f4_c4r1",  PAT_MOD3, 4, 1);
    do_read("f4_c13r9", PAT_MOD3, 13, 9);

    // Reset mid-frame (asynchronous, away from the clock edge).
    write_pixels(PAT_CHK, 100, 1'b0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_col_vld",  32'(col_vld),        32'd0);
    check("mid_rst_col_data", 32'(col_data),       32'd0);
    check("mid_rst_cal",      32'(cal_start),      32'd0);
    check("mid_rst_in_ready", 32'(in_ready),       32'd1);
    check("mid_rst_rd_bank",  32'(rd_bank),        32'd0);
    check("mid_rst_ovf",      32'(ovf),            32'd0);
    check("mid_rst_states",   32'(bank_state_dbg), 32'h0);
    tick();
    tick();
    s_rst_n = 1'b1;
    tick();

    // Fresh all-ones frame after reset lands in bank 0.
    write_pixels(PAT_ONES, IMG_W * IMG_H, 1'b0);
    check("f5_cal_start", 32'(cal_start), 32'd1);
    check("f5_rd_bank",   32'(rd_bank),   32'd0);
    do_read("f5_c7r0", PAT_ONES, 7, 0);
`ifdef CONV_WIN_ZERO_PAD_EN
    check("pad_top_lit", 32'(col_data), 32'h1C);
    do_read("f5_c7r27", PAT_ONES, 7, 27);
    check("pad_bot_lit", 32'(col_data), 32'h07);
`else
    check("ones_top_lit", 32'(col_data), 32'h1F);
    do_read("f5_c7r23", PAT_ONES, 7, 23);
    check("ones_r23_lit", 32'(col_data), 32'h1F);
    do_read("f5_c7r24", PAT_ONES, 7, 24);
    check("ones_r24_lit", 32'(col_data), 32'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
